// File: rtl/qspi_mem_target_if.sv
// rtl/qspi_mem_target_if.sv - SPI pin bundle between a quad-SPI master and qspi_mem_target
interface qspi_mem_target_if;
   logic       spi_clk_in;
   logic       spi_select_n;
   logic [3:0] spi_data_in;
   logic [3:0] spi_data_out;
   logic [3:0] spi_data_oe;
   logic       active;
   logic       cmd_error;

   modport master (
      output spi_clk_in, spi_select_n, spi_data_in,
      input  spi_data_out, spi_data_oe, active, cmd_error
   );

   modport slave (
      input  spi_clk_in, spi_select_n, spi_data_in,
      output spi_data_out, spi_data_oe, active, cmd_error
   );
endinterface

// File: rtl/qspi_mem_target.sv
// rtl/qspi_mem_target.sv - quad-SPI RAM target serving 0x38 quad-write and 0xEB quad-read
module qspi_mem_target #(
   parameter int DATA_BUS_WIDTH = 8,
   parameter int MEM_ADDR_WIDTH = 6,
   parameter int DUMMY_CYCLES   = 4
) (
   input logic              clock,
   input logic              reset,
   qspi_mem_target_if.slave bus
);
   localparam int AW    = MEM_ADDR_WIDTH;
   localparam int DEPTH = 2 ** AW;
   localparam int SH    = (AW > 8) ? AW : 8;
   localparam logic [7:0]    DUMMY_LAST = 8'(DUMMY_CYCLES);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_READ, ST_WRITE, ST_IGNORE
   } state_t;

   state_t                    state_q;
   logic                      clk_s1_q, clk_s2_q, clk_p_q;
   logic                      sel_s1_q, sel_s2_q, sel_p_q;
   logic [3:0]                data_s1_q, data_s2_q;
   logic [7:0]                cnt_q;
   logic                      is_read_q;
   logic                      half_q;
   logic [3:0]                hi_q;
   logic [SH-1:0]             shift_q;
   logic [AW-1:0]             ptr_q;
   logic [3:0]                dout_q;
   logic [3:0]                oe_q;
   logic                      active_q;
   logic                      cmd_error_q;
   logic [DATA_BUS_WIDTH-1:0] mem_q [0:DEPTH-1];

   logic                      clk_rise, clk_fall;
   logic [SH-1:0]             sh_d;
   logic [DATA_BUS_WIDTH-1:0] rd_byte;

   assign clk_rise = clk_s2_q & ~clk_p_q;
   assign clk_fall = ~clk_s2_q & clk_p_q;
   assign sh_d     = {shift_q[SH-5:0], data_s2_q};
   assign rd_byte  = mem_q[ptr_q];

   // Select chain resets low so a select already held low at release never looks like a fresh assertion.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         clk_s1_q    <= 1'b0;
         clk_s2_q    <= 1'b0;
         clk_p_q     <= 1'b0;
         sel_s1_q    <= 1'b0;
         sel_s2_q    <= 1'b0;
         sel_p_q     <= 1'b0;
         data_s1_q   <= 4'h0;
         data_s2_q   <= 4'h0;
         cnt_q       <= 8'd0;
         is_read_q   <= 1'b0;
         half_q      <= 1'b0;
         hi_q        <= 4'h0;
         shift_q     <= '0;
         ptr_q       <= '0;
         dout_q      <= 4'h0;
         oe_q        <= 4'h0;
         active_q    <= 1'b0;
         cmd_error_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         clk_s1_q  <= bus.spi_clk_in;
         clk_s2_q  <= clk_s1_q;
         clk_p_q   <= clk_s2_q;
         sel_s1_q  <= bus.spi_select_n;
         sel_s2_q  <= sel_s1_q;
         sel_p_q   <= sel_s2_q;
         data_s1_q <= bus.spi_data_in;
         data_s2_q <= data_s1_q;

         if (sel_s2_q) begin
            state_q  <= ST_IDLE;
            oe_q     <= 4'h0;
            dout_q   <= 4'h0;
            active_q <= 1'b0;
            half_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (sel_p_q) begin
                     state_q  <= ST_CMD;
                     cnt_q    <= 8'd0;
                     active_q <= 1'b1;
                  end
               end
               ST_CMD: begin
                  if (clk_rise) begin
                     shift_q <= sh_d;
                     if (cnt_q == 8'd1) begin
                        cnt_q <= 8'd0;
                        if (sh_d[7:0] == 8'h38) begin
                           is_read_q <= 1'b0;
                           state_q   <= ST_ADDR;
                        end else if (sh_d[7:0] == 8'hEB) begin
                           is_read_q <= 1'b1;
                           state_q   <= ST_ADDR;
                        end else begin
                           state_q     <= ST_IGNORE;
                           cmd_error_q <= 1'b1;
                        end
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               ST_ADDR: begin
                  if (clk_rise) begin
                     shift_q <= sh_d;
                     if (cnt_q == 8'd5) begin
                        ptr_q   <= sh_d[AW-1:0];
                        cnt_q   <= 8'd0;
                        half_q  <= 1'b0;
                        state_q <= is_read_q ? ST_DUMMY : ST_WRITE;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               ST_DUMMY: begin
                  // The fall that trails the final address rise arrives here with cnt_q==0 and is ignored.
                  if (clk_rise) begin
                     cnt_q <= cnt_q + 8'd1;
                  end else if (clk_fall && cnt_q == DUMMY_LAST) begin
                     state_q <= ST_READ;
                     oe_q    <= 4'hF;
                     dout_q  <= rd_byte[7:4];
                     half_q  <= 1'b1;
                  end
               end
               ST_READ: begin
                  if (clk_fall) begin
                     if (half_q) begin
                        dout_q <= rd_byte[3:0];
                        ptr_q  <= ptr_q + PTR_ONE;
                        half_q <= 1'b0;
                     end else begin
                        dout_q <= rd_byte[7:4];
                        half_q <= 1'b1;
                     end
                  end
               end
               ST_WRITE: begin
                  if (clk_rise) begin
                     if (!half_q) begin
                        hi_q   <= data_s2_q;
                        half_q <= 1'b1;
                     end else begin
                        mem_q[ptr_q] <= {hi_q, data_s2_q};
                        ptr_q        <= ptr_q + PTR_ONE;
                        half_q       <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.spi_data_out = dout_q;
   assign bus.spi_data_oe  = oe_q;
   assign bus.active       = active_q;
   assign bus.cmd_error    = cmd_error_q;
endmodule
